fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 16, width of program counter and of LUT branch-target data.
REQ-002 Parameter LUT_AW, default 8, width of LUT index driven to the branch-target LUT.
REQ-003 Parameter START_PC, default 16'h0000, PC value loaded on every start.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  one-cycle pulse; begins execution from START_PC.
REQ-007 stall  input  1  hold all state this cycle.
REQ-008 halt_req  input  1  decoded halt instruction.
REQ-009 branch_en  input  1  decoded branch instruction.
REQ-010 branch_cond  input  1  branch condition true.
REQ-011 branch_idx  input  LUT_AW  LUT index from branch instruction.
REQ-012 lut_out  input  PC_W  target returned combinationally by the external LUT.
REQ-013 lut_addr  output  LUT_AW  registered index to the external LUT.
REQ-014 pc  output  PC_W  current fetch address.
REQ-015 fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-016 done  output  1  program halted.

Function
REQ-017 States SHALL be IDLE, RUN, RESOLVE, HALTED.
REQ-018 IDLE: start -> RUN, pc<=START_PC; other inputs ignored.
REQ-019 RUN, priority halt_req > taken branch > increment; each applies only when stall=0.
REQ-020 RUN, halt_req=1 -> HALTED, done<=1, pc held.
REQ-021 RUN, branch_en=1 and branch_cond=1 -> lut_addr<=branch_idx, RESOLVE, pc held.
REQ-022 RUN, otherwise (including branch_en=1, branch_cond=0) -> pc<=pc+1 modulo 2^PC_W (16'hFFFF wraps to 16'h0000).
REQ-023 RESOLVE: pc<=lut_out, -> RUN; branch latency SHALL be exactly 2 cycles from branch decode to target pc.
REQ-024 HALTED: done held 1; start -> RUN, pc<=START_PC, done<=0.
REQ-025 start SHALL be ignored in RUN and RESOLVE.
REQ-026 stall=1 SHALL freeze state, pc, lut_addr, done in IDLE, RUN and RESOLVE; stall SHALL be ignored in HALTED.
REQ-027 fetch_valid SHALL be 1 exactly in RUN and 0 in IDLE, RESOLVE, HALTED; combinational from state.
REQ-028 lut_addr SHALL change only on a taken branch (or link call) and otherwise hold its last value.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, pc=0, lut_addr=0, done=0, fetch_valid=0, regardless of clk.
REQ-030 Reset during RESOLVE SHALL abandon the branch; no lut_out load after release.
REQ-031 First start after reset release SHALL behave as REQ-018.

Configuration
REQ-032 Macro CALL_LINK_EN defined: adds inputs call_en, ret_en (1 bit each) and internal PC_W link register, reset 0.
REQ-033 With CALL_LINK_EN, call_en in RUN (priority below halt_req, above branch) -> link<=pc+1, lut_addr<=branch_idx, RESOLVE unconditionally.
REQ-034 With CALL_LINK_EN, ret_en in RUN (priority below call_en) -> pc<=link in one cycle, state stays RUN, no LUT access.
REQ-035 Without CALL_LINK_EN: ports call_en/ret_en and link register SHALL not exist; behaviour per REQ-017..031 only.

Structure
REQ-036 Shared package fetch_pkg SHALL hold PC_W and LUT_AW defaults and the state enum typedef fetch_state_t.
REQ-037 No sub-module; LUT is instantiated by the parent and connected via lut_addr/lut_out.

Verification
REQ-038 Reset, start, 5 cycles no branch -> pc 0,1,2,3,4, fetch_valid=1 from first RUN cycle.
REQ-039 pc=0x0010, branch_en=1, branch_cond=1, branch_idx=0x03, LUT[3]=0x00A0 -> lut_addr=0x03 next cycle, fetch_valid=0 one cycle, pc=0x00A0 following cycle.
REQ-040 branch_en=1, branch_cond=0 at pc=0x0010 -> pc=0x0011, lut_addr unchanged.
REQ-041 pc=0xFFFF no branch -> pc=0x0000; halt_req and branch_en same cycle -> HALTED, done=1, lut_addr unchanged; stall=1 three cycles in RUN -> pc frozen.
REQ-042 rst_n low mid-RESOLVE -> outputs 0 asynchronously, state IDLE, no target load after release.
REQ-043 With CALL_LINK_EN: call_en at pc=0x0020, idx=0x05, LUT[5]=0x0100 -> pc=0x0100; later ret_en -> pc=0x0021 next cycle.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch controller: default widths and the
// controller state type. Imported by fetch_ctrl.
package fetch_pkg;

    // Default program-counter / LUT-target width
    localparam int FETCH_PC_W   = 16;
    // Default branch-target LUT index width
    localparam int FETCH_LUT_AW = 8;

    // Controller states: waiting for start, fetching, waiting one cycle for
    // the LUT target, stopped by a halt instruction
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_RESOLVE,
        ST_HALTED
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program-counter sequencer with LUT-resolved branches.
// A taken branch registers its LUT index, spends one cycle in RESOLVE while
// the external LUT answers, then loads the returned target as the new pc.
// Optional feature macro: CALL_LINK_EN adds call_en/ret_en and a link
// register for single-level call/return.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                PC_W     = FETCH_PC_W,
    parameter int                LUT_AW   = FETCH_LUT_AW,
    parameter logic [PC_W-1:0]   START_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              halt_req,
    input  logic              branch_en,
    input  logic              branch_cond,
    input  logic [LUT_AW-1:0] branch_idx,
`ifdef CALL_LINK_EN
    input  logic              call_en,
    input  logic              ret_en,
`endif
    input  logic [PC_W-1:0]   lut_out,
    output logic [LUT_AW-1:0] lut_addr,
    output logic [PC_W-1:0]   pc,
    output logic              fetch_valid,
    output logic              done
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    fetch_state_t state;

`ifdef CALL_LINK_EN
    logic [PC_W-1:0] link;
`endif

    // Sequencer: state, pc, LUT index and done flag, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= '0;
            lut_addr <= '0;
            done     <= 1'b0;
`ifdef CALL_LINK_EN
            link     <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stall && start) begin
                        state <= ST_RUN;
                        pc    <= START_PC;
                    end
                end

                ST_RUN: begin
                    if (!stall) begin
                        if (halt_req) begin
                            state <= ST_HALTED;
                            done  <= 1'b1;
                        end
`ifdef CALL_LINK_EN
                        else if (call_en) begin
                            link     <= pc + PC_ONE;
                            lut_addr <= branch_idx;
                            state    <= ST_RESOLVE;
                        end else if (ret_en) begin
                            pc <= link;
                        end
`endif
                        else if (branch_en && branch_cond) begin
                            lut_addr <= branch_idx;
                            state    <= ST_RESOLVE;
                        end else begin
                            pc <= pc + PC_ONE;
                        end
                    end
                end

                ST_RESOLVE: begin
                    // lut_out already reflects the registered lut_addr
                    if (!stall) begin
                        pc    <= lut_out;
                        state <= ST_RUN;
                    end
                end

                ST_HALTED: begin
                    // stall has no effect once halted
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= START_PC;
                        done  <= 1'b0;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // pc is a usable fetch address only while running
    always_comb begin
        fetch_valid = (state == ST_RUN);
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: vector table, directed corner
// sequences, and randomized stimulus against a behavioural model.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, stall, halt_req, branch_en, branch_cond;
    logic [7:0]  branch_idx;
    logic [15:0] lut_out;
    logic [7:0]  lut_addr;
    logic [15:0] pc;
    logic        fetch_valid, done;
`ifdef CALL_LINK_EN
    logic        call_en, ret_en;
`endif

    int n_pass  = 0;
    int n_total = 0;

    fetch_ctrl #(.PC_W(16), .LUT_AW(8), .START_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stall      (stall),
        .halt_req   (halt_req),
        .branch_en  (branch_en),
        .branch_cond(branch_cond),
        .branch_idx (branch_idx),
`ifdef CALL_LINK_EN
        .call_en    (call_en),
        .ret_en     (ret_en),
`endif
        .lut_out    (lut_out),
        .lut_addr   (lut_addr),
        .pc         (pc),
        .fetch_valid(fetch_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External branch-target LUT contents
    function automatic logic [15:0] lut_fn(input logic [7:0] i);
        case (i)
            8'h03:   return 16'h00A0;
            8'h05:   return 16'h0100;
            8'h0A:   return 16'h0020;
            8'hEE:   return 16'hFFFF;
            default: return {i, ~i};
        endcase
    endfunction

    always_comb lut_out = lut_fn(lut_addr);

    // ---------------- behavioural reference model ----------------
    // mode: 0 waiting for start, 1 fetching, 2 target pending, 3 halted
    int          m_mode;
    int          m_pc;
    int          m_lut;
    bit          m_done;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_lut = 0; m_done = 0;
    endtask

    task automatic model_step();
        if (m_mode == 3) begin
            if (start) begin m_mode = 1; m_pc = 0; m_done = 0; end
        end else if (!stall) begin
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_pc = 0; end
            end else if (m_mode == 2) begin
                m_pc = int'(lut_fn(8'(m_lut)));
                m_mode = 1;
            end else if (halt_req) begin
                m_mode = 3; m_done = 1;
            end else if (branch_en && branch_cond) begin
                m_lut = int'(branch_idx);
                m_mode = 2;
            end else begin
                m_pc = (m_pc + 1) % 65536;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else
            n_pass++;
    endtask

    task automatic chk_out(input string nm, input logic [15:0] e_pc, input logic e_v,
                           input logic e_done, input logic [7:0] e_lut);
        chk({nm, ".pc"},    32'(pc),          32'(e_pc));
        chk({nm, ".valid"}, 32'(fetch_valid), 32'(e_v));
        chk({nm, ".done"},  32'(done),        32'(e_done));
        chk({nm, ".lut"},   32'(lut_addr),    32'(e_lut));
    endtask

    task automatic step(input logic s_start, input logic s_stall, input logic s_halt,
                        input logic s_ben, input logic s_bcond, input logic [7:0] s_idx);
        start = s_start; stall = s_stall; halt_req = s_halt;
        branch_en = s_ben; branch_cond = s_bcond; branch_idx = s_idx;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_step();
        step(0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic do_reset();
        start = 0; stall = 0; halt_req = 0; branch_en = 0; branch_cond = 0;
        branch_idx = '0;
`ifdef CALL_LINK_EN
        call_en = 0; ret_en = 0;
`endif
        rst_n = 1'b0;
        model_reset();
        #3;
        chk_out("reset", 16'h0000, 0, 0, 8'h00);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
    endtask

    task automatic run_to_0x10();
        do_reset();
        step(1, 0, 0, 0, 0, 8'h00);
        repeat (16) idle_step();
    endtask

    typedef struct {
        logic       start, stall, halt, ben, bcond;
        logic [7:0] idx;
        logic [15:0] e_pc;
        logic       e_v, e_done;
        logic [7:0] e_lut;
    } vec_t;

    vec_t tbl[15];

    function automatic vec_t mk(input logic s, input logic st, input logic h, input logic b,
                                input logic c, input logic [7:0] i, input logic [15:0] p,
                                input logic v, input logic d, input logic [7:0] l);
        vec_t r;
        r.start = s; r.stall = st; r.halt = h; r.ben = b; r.bcond = c; r.idx = i;
        r.e_pc = p; r.e_v = v; r.e_done = d; r.e_lut = l;
        return r;
    endfunction

    initial begin
        //            st stl hlt ben bc idx    pc        v  d  lut
        tbl[0]  = mk(1, 0, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h00);
        tbl[1]  = mk(0, 0, 0, 0, 0, 8'h00, 16'h0001, 1, 0, 8'h00);
        tbl[2]  = mk(0, 0, 0, 0, 0, 8'h00, 16'h0002, 1, 0, 8'h00);
        tbl[3]  = mk(0, 0, 0, 0, 0, 8'h00, 16'h0003, 1, 0, 8'h00);
        tbl[4]  = mk(0, 0, 0, 0, 0, 8'h00, 16'h0004, 1, 0, 8'h00);
        tbl[5]  = mk(0, 1, 0, 0, 0, 8'h00, 16'h0004, 1, 0, 8'h00);
        tbl[6]  = mk(0, 1, 1, 1, 1, 8'h09, 16'h0004, 1, 0, 8'h00);
        tbl[7]  = mk(0, 1, 0, 0, 0, 8'h00, 16'h0004, 1, 0, 8'h00);
        tbl[8]  = mk(1, 0, 0, 0, 0, 8'h00, 16'h0005, 1, 0, 8'h00);
        tbl[9]  = mk(0, 0, 0, 1, 0, 8'h09, 16'h0006, 1, 0, 8'h00);
        tbl[10] = mk(0, 0, 0, 1, 1, 8'h03, 16'h0006, 0, 0, 8'h03);
        tbl[11] = mk(0, 1, 0, 0, 0, 8'h00, 16'h0006, 0, 0, 8'h03);
        tbl[12] = mk(0, 0, 0, 0, 0, 8'h00, 16'h00A0, 1, 0, 8'h03);
        tbl[13] = mk(0, 0, 1, 1, 1, 8'h07, 16'h00A0, 0, 1, 8'h03);
        tbl[14] = mk(1, 1, 0, 0, 0, 8'h00, 16'h0000, 1, 0, 8'h03);

        // Vector table from reset
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].start, tbl[i].stall, tbl[i].halt, tbl[i].ben, tbl[i].bcond, tbl[i].idx);
            chk_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_v, tbl[i].e_done, tbl[i].e_lut);
        end

        // Taken branch at 0x0010: two-cycle latency to the LUT target
        run_to_0x10();
        chk_out("at10", 16'h0010, 1, 0, 8'h00);
        step(0, 0, 0, 1, 1, 8'h03);
        chk_out("br_resolve", 16'h0010, 0, 0, 8'h03);
        idle_step();
        chk_out("br_target", 16'h00A0, 1, 0, 8'h03);

        // Untaken branch at 0x0010 simply increments
        run_to_0x10();
        step(0, 0, 0, 1, 0, 8'h03);
        chk_out("br_untaken", 16'h0011, 1, 0, 8'h00);

        // pc wraps from 0xFFFF to 0x0000
        step(0, 0, 0, 1, 1, 8'hEE);
        idle_step();
        chk_out("at_ffff", 16'hFFFF, 1, 0, 8'hEE);
        idle_step();
        chk_out("wrap", 16'h0000, 1, 0, 8'hEE);

        // Reset asserted mid-RESOLVE abandons the branch
        step(0, 0, 0, 1, 1, 8'h03);
        chk_out("pre_rst", 16'h0000, 0, 0, 8'h03);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        chk_out("async_rst", 16'h0000, 0, 0, 8'h00);
        #3 rst_n = 1'b1;
        idle_step();
        chk_out("post_rst1", 16'h0000, 0, 0, 8'h00);
        idle_step();
        chk_out("post_rst2", 16'h0000, 0, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        chk_out("restart", 16'h0000, 1, 0, 8'h00);

`ifdef CALL_LINK_EN
        // Call to LUT[5] from 0x0020, then return to 0x0021
        do_reset();
        step(1, 0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 1, 8'h0A);
        idle_step();
        chk_out("call_at20", 16'h0020, 1, 0, 8'h0A);
        call_en = 1; branch_idx = 8'h05;
        @(posedge clk); #1;
        call_en = 0;
        chk_out("call_resolve", 16'h0020, 0, 0, 8'h05);
        @(posedge clk); #1;
        chk_out("call_target", 16'h0100, 1, 0, 8'h05);
        ret_en = 1;
        @(posedge clk); #1;
        ret_en = 0;
        chk_out("ret", 16'h0021, 1, 0, 8'h05);
`endif

        // Randomized stimulus against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            step(($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 16) == 0,
                 ($urandom % 3) == 0, ($urandom % 2) == 1,
                 (($urandom % 8) == 0) ? 8'hEE : 8'($urandom));
            chk_out($sformatf("rnd%0d", c), 16'(m_pc), m_mode == 1, m_done, 8'(m_lut));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
